// File: rtl/fmap_writer_pkg.sv
// Shared CNN types for the feature-map writer: element packet, state enum, element width.
// CNN_XLEN may be overridden on the command line; 16 bits is the default element width.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

package fmap_writer_pkg;

  typedef struct packed {
    logic                 valid;
    logic [`CNN_XLEN-1:0] data;
    logic                 last;
  } PE_OUT_PACKET;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } fmap_state_t;

  localparam int STALL_CNT_WID = 16;

endpackage

// File: rtl/fmap_pack_reg.sv
// Lane packing register: collects elements into a word, generates the lane mask,
// and holds a completed word when it cannot be handed off immediately.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

module fmap_pack_reg
  import fmap_writer_pkg::*;
#(
  parameter  int DATA_WID = `CNN_XLEN,
  parameter  int PACK_NUM = 4,
  localparam int LANE_WID = $clog2(PACK_NUM)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic [DATA_WID-1:0]          push_data,
  input  logic                         push_last,
  input  logic                         take,
  output logic                         word_ready,
  output logic [PACK_NUM*DATA_WID-1:0] word_data,
  output logic [PACK_NUM-1:0]          word_mask,
  output logic                         full
);

  logic [PACK_NUM*DATA_WID-1:0] data_q;
  logic [PACK_NUM*DATA_WID-1:0] merged_data;
  logic [PACK_NUM-1:0]          mask_q;
  logic [PACK_NUM-1:0]          merged_mask;
  logic [LANE_WID-1:0]          lane_q;
  logic                         full_q;
  logic                         closing;

  // Unfilled lanes are kept at zero, so a partial word needs no extra masking of data.
  always_comb begin
    merged_data = data_q;
    merged_data[int'(lane_q)*DATA_WID +: DATA_WID] = push_data;
    merged_mask = '0;
    for (int i = 0; i < PACK_NUM; i++) begin
      merged_mask[i] = (i <= int'(lane_q));
    end
  end

  assign closing    = (lane_q == LANE_WID'(PACK_NUM-1)) || push_last;
  assign word_ready = full_q || (push && closing);
  assign word_data  = full_q ? data_q : merged_data;
  assign word_mask  = full_q ? mask_q : merged_mask;
  assign full       = full_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      data_q <= '0;
      mask_q <= '0;
      lane_q <= '0;
      full_q <= 1'b0;
    end else if (full_q) begin
      if (take) begin
        data_q <= '0;
        mask_q <= '0;
        lane_q <= '0;
        full_q <= 1'b0;
        // An element accepted on the handoff edge starts the next word in lane 0.
        if (push) begin
          data_q[DATA_WID-1:0] <= push_data;
          if (push_last) begin
            full_q <= 1'b1;
            mask_q <= PACK_NUM'(1);
          end else begin
            lane_q <= LANE_WID'(1);
          end
        end
      end
    end else if (push) begin
      if (closing && !take) begin
        data_q <= merged_data;
        mask_q <= merged_mask;
        full_q <= 1'b1;
        lane_q <= '0;
      end else if (closing) begin
        data_q <= '0;
        lane_q <= '0;
      end else begin
        data_q <= merged_data;
        lane_q <= lane_q + LANE_WID'(1);
      end
    end
  end

endmodule

// File: rtl/fmap_writer.sv
// Feature-map writer: packs activation elements into memory words and issues them
// through a req/gnt port. Optional stall counter enabled by FMAP_WRITER_STALL_CNT_EN.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

module fmap_writer
  import fmap_writer_pkg::*;
#(
  parameter int DATA_WID = `CNN_XLEN,
  parameter int PACK_NUM = 4,
  parameter int ADDR_WID = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  PE_OUT_PACKET                 relu_out_pk,
  input  logic                         start,
  input  logic [ADDR_WID-1:0]          base_addr,
  output logic                         mem_wr_req,
  input  logic                         mem_wr_gnt,
  output logic [ADDR_WID-1:0]          mem_wr_addr,
  output logic [PACK_NUM*DATA_WID-1:0] mem_wr_data,
  output logic [PACK_NUM-1:0]          mem_wr_mask,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
`ifdef FMAP_WRITER_STALL_CNT_EN
  output logic [STALL_CNT_WID-1:0]     stall_cnt,
`endif
  output fmap_state_t                  state
);

  // Handshake: a write completes on any edge where mem_wr_req and mem_wr_gnt are both
  // high; addr/data/mask are stable while req is high and gnt low; the input stream
  // has no back-pressure, so elements that cannot be stored are dropped.

  fmap_state_t                  state_q, state_d;
  logic                         req_q;
  logic [ADDR_WID-1:0]          addr_q;
  logic [PACK_NUM*DATA_WID-1:0] data_q;
  logic [PACK_NUM-1:0]          mask_q;
  logic                         overflow_q;

  logic                         start_ok;
  logic                         granted;
  logic                         pend_free;
  logic                         elem;
  logic                         push;
  logic                         take;
  logic                         drop;
  logic                         word_ready;
  logic                         pack_full;
  logic [PACK_NUM*DATA_WID-1:0] word_data;
  logic [PACK_NUM-1:0]          word_mask;

  assign start_ok  = (state_q == ST_IDLE) && start;
  assign granted   = req_q && mem_wr_gnt;
  assign pend_free = !req_q || mem_wr_gnt;
  assign elem      = (state_q == ST_PACK) && relu_out_pk.valid;
  assign push      = elem && (!pack_full || pend_free);
  assign drop      = elem && pack_full && !pend_free;
  assign take      = word_ready && pend_free;

  fmap_pack_reg #(
    .DATA_WID (DATA_WID),
    .PACK_NUM (PACK_NUM)
  ) u_pack (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .push       (push),
    .push_data  (relu_out_pk.data[DATA_WID-1:0]),
    .push_last  (relu_out_pk.last),
    .take       (take),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_mask  (word_mask),
    .full       (pack_full)
  );

  // A last element still closes the frame even if it was dropped; FLUSH drains what is held.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_PACK;
      ST_PACK:  if (relu_out_pk.valid && relu_out_pk.last) state_d = ST_FLUSH;
      ST_FLUSH: if (granted && !pack_full) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        addr_q     <= base_addr;
        overflow_q <= 1'b0;
      end
      if (drop) overflow_q <= 1'b1;
      if (granted) addr_q <= addr_q + ADDR_WID'(1);
      if (take) begin
        req_q  <= 1'b1;
        data_q <= word_data;
        mask_q <= word_mask;
      end else if (granted) begin
        req_q  <= 1'b0;
        mask_q <= '0;
      end
    end
  end

`ifdef FMAP_WRITER_STALL_CNT_EN
  logic [STALL_CNT_WID-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      stall_q <= '0;
    end else if (req_q && !mem_wr_gnt && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_WID'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign mem_wr_req  = req_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = data_q;
  assign mem_wr_mask = mask_q;
  assign busy        = (state_q == ST_PACK) || (state_q == ST_FLUSH);
  assign done        = (state_q == ST_DONE);
  assign overflow    = overflow_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fmap_writer.sv
// Bench for fmap_writer: table of frames, hand-written overflow/reset/idle sequences,
// and randomized frames checked against a word-chunking reference model.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

module tb_fmap_writer;
  import fmap_writer_pkg::*;

  localparam int DW = `CNN_XLEN;
  localparam int PN = 4;
  localparam int AW = 10;
  localparam int WW = PN * DW;
  localparam int EW = AW + WW + PN;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  PE_OUT_PACKET      pk;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic              mem_wr_req;
  logic              gnt;
  logic [AW-1:0]     wr_addr;
  logic [WW-1:0]     wr_data;
  logic [PN-1:0]     wr_mask;
  logic              busy, done, overflow;
  fmap_state_t       state;
`ifdef FMAP_WRITER_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  always #5 clk = ~clk;

  fmap_writer #(.DATA_WID(DW), .PACK_NUM(PN), .ADDR_WID(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .relu_out_pk (pk),
    .start       (start),
    .base_addr   (base_addr),
    .mem_wr_req  (mem_wr_req),
    .mem_wr_gnt  (gnt),
    .mem_wr_addr (wr_addr),
    .mem_wr_data (wr_data),
    .mem_wr_mask (wr_mask),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
`ifdef FMAP_WRITER_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .state       (state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] vals[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            wr_cnt, done_cnt, flush_seen, outstanding;
  logic [AW-1:0] last_addr;
  logic [PN-1:0] last_mask;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (!reset) begin
      if (done) done_cnt++;
      if (state == ST_FLUSH) flush_seen++;
      if (mem_wr_req && gnt) begin
        wr_cnt++;
        last_addr = wr_addr;
        last_mask = wr_mask;
        if (outstanding > 0) outstanding--;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0h data %0h mask %0h, none required", wr_addr, wr_data, wr_mask);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 128'(wr_addr), 128'(e[EW-1 -: AW]));
          check("write_data", 128'(wr_data), 128'(e[PN +: WW]));
          check("write_mask", 128'(wr_mask), 128'(e[PN-1:0]));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Frame elements split into words of PN in order; the tail word masks only its filled lanes.
  task automatic expect_frame(input logic [AW-1:0] base, input int n);
    int nw;
    logic [WW-1:0] d;
    logic [PN-1:0] m;
    nw = (n + PN - 1) / PN;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      m = '0;
      for (int l = 0; l < PN; l++) begin
        if (w * PN + l < n) begin
          d[l*DW +: DW] = vals[w*PN + l];
          m[l] = 1'b1;
        end
      end
      exp_q.push_back({base + AW'(w), d, m});
    end
  endtask

  task automatic push_word(input logic [AW-1:0] a, input int d0, input int d1,
                           input int d2, input int d3, input logic [PN-1:0] m);
    exp_q.push_back({a, DW'(d3), DW'(d2), DW'(d1), DW'(d0), m});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic l, input logic g);
    pk.valid = v;
    pk.data  = d;
    pk.last  = l;
    gnt      = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    start     = 1'b1;
    base_addr = base;
    cyc(1'b0, '0, 1'b0, 1'b0);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int gnt_pct);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 300) begin
      cyc(1'b0, '0, 1'b0, $urandom_range(99, 0) < gnt_pct);
      k++;
    end
  endtask

  task automatic run_frame(input logic [AW-1:0] base, input int n, input int gnt_pct,
                           input int gap_pct, input bit stray, input bit rnd,
                           input int ew, input logic [AW-1:0] ela, input logic [PN-1:0] elm);
    int  sent, lane, guard;
    bit  g, closes;
    vals.delete();
    for (int i = 0; i < n; i++) vals.push_back(rnd ? DW'($urandom) : DW'(i + 1));
    expect_frame(base, n);
    wr_cnt = 0; done_cnt = 0; flush_seen = 0; outstanding = 0;
    do_start(base);
    sent = 0; lane = 0; guard = 0;
    while (sent < n && guard < 2000) begin
      g = ($urandom_range(99, 0) < gnt_pct);
      if (stray && sent == 2) begin
        start     = 1'b1;
        base_addr = ~base;
      end
      if (outstanding < 2 && $urandom_range(99, 0) >= gap_pct) begin
        closes = (lane == PN - 1) || (sent == n - 1);
        if (closes) outstanding++;
        cyc(1'b1, vals[sent], sent == n - 1, g);
        lane = closes ? 0 : lane + 1;
        sent++;
      end else begin
        cyc(1'b0, '0, 1'b0, g);
      end
      start = 1'b0;
      guard++;
    end
    wait_done(gnt_pct < 25 ? 25 : gnt_pct);
    check("frame_done_count", 128'(done_cnt), 128'(1));
    check("frame_write_count", 128'(wr_cnt), 128'(ew));
    check("frame_last_addr", 128'(last_addr), 128'(ela));
    check("frame_last_mask", 128'(last_mask), 128'(elm));
    check("frame_flush_seen", 128'(flush_seen > 0), 128'(1));
    check("frame_overflow", 128'(overflow), 128'(0));
    check("frame_idle_after", 128'(state), 128'(ST_IDLE));
    check("frame_busy_after", 128'(busy), 128'(0));
    check("frame_exp_empty", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   128'(mem_wr_req), 128'(0));
    check({tag, "_busy"},  128'(busy), 128'(0));
    check({tag, "_done"},  128'(done), 128'(0));
    check({tag, "_ovf"},   128'(overflow), 128'(0));
    check({tag, "_addr"},  128'(wr_addr), 128'(0));
    check({tag, "_data"},  128'(wr_data), 128'(0));
    check({tag, "_mask"},  128'(wr_mask), 128'(0));
    check({tag, "_state"}, 128'(state), 128'(ST_IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] base;
    int            n;
    int            gnt_pct;
    bit            stray;
    int            exp_words;
    logic [AW-1:0] exp_last_addr;
    logic [PN-1:0] exp_last_mask;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int            n, ew, pct;
    logic [AW-1:0] b;
    logic [PN-1:0] lm;

    tbl[0] = '{10'h010,  8, 100, 1'b0, 2, 10'h011, 4'hF};
    tbl[1] = '{10'h020,  6, 100, 1'b1, 2, 10'h021, 4'h3};
    tbl[2] = '{10'h3FF,  8, 100, 1'b0, 2, 10'h000, 4'hF};
    tbl[3] = '{10'h100,  1, 100, 1'b0, 1, 10'h100, 4'h1};
    tbl[4] = '{10'h200,  7,  50, 1'b1, 2, 10'h201, 4'h7};
    tbl[5] = '{10'h3FE, 12,  40, 1'b0, 3, 10'h000, 4'hF};

    reset = 1'b1; start = 1'b0; base_addr = '0; gnt = 1'b0;
    pk = '0;
    wr_cnt = 0; done_cnt = 0; flush_seen = 0; outstanding = 0;
    last_addr = '0; last_mask = '0;
    @(posedge clk); #1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    check_all_zero("reset");
    reset = 1'b0;

    // Elements while idle are ignored and never raise overflow.
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(i + 40), i == 4, 1'b1);
    check("idle_state", 128'(state), 128'(ST_IDLE));
    check("idle_req", 128'(mem_wr_req), 128'(0));
    check("idle_ovf", 128'(overflow), 128'(0));

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].base, tbl[i].n, tbl[i].gnt_pct, 0, tbl[i].stray, 1'b0,
                tbl[i].exp_words, tbl[i].exp_last_addr, tbl[i].exp_last_mask);
    end

    // Grant withheld: one word pending, four held in the pack register, four dropped.
    push_word(10'h040, 1, 2, 3, 4, 4'hF);
    push_word(10'h041, 5, 6, 7, 8, 4'hF);
    push_word(10'h042, 99, 0, 0, 0, 4'h1);
    done_cnt = 0;
    do_start(10'h040);
    for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    check("ovf_req_up", 128'(mem_wr_req), 128'(1));
    for (int i = 5; i <= 12; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("ovf_flag", 128'(overflow), 128'(1));
    check("ovf_held_data", 128'(wr_data), 128'({16'd4, 16'd3, 16'd2, 16'd1}));
    check("ovf_held_addr", 128'(wr_addr), 128'(10'h040));
    check("ovf_held_mask", 128'(wr_mask), 128'(4'hF));
`ifdef FMAP_WRITER_STALL_CNT_EN
    check("ovf_stall_cnt", 128'(stall_cnt), 128'(10));
`endif
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, DW'(99), 1'b1, 1'b1);
    wait_done(100);
    check("ovf_done", 128'(done_cnt), 128'(1));
    check("ovf_sticky", 128'(overflow), 128'(1));
    check("ovf_exp_empty", 128'(exp_q.size()), 128'(0));
    exp_q.delete();

    // Reset while a word is pending: nothing is written, everything returns to zero.
    do_start(10'h0AA);
    for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(i + 100), 1'b0, 1'b0);
    check("rst_req_up", 128'(mem_wr_req), 128'(1));
    reset = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b1);
    check_all_zero("rst_mid");
    reset = 1'b0;
    run_frame(10'h0AB, 5, 100, 0, 1'b0, 1'b1, 2, 10'h0AC, 4'h1);

    for (int r = 0; r < 8; r++) begin
      b   = AW'($urandom_range(1023, 0));
      n   = $urandom_range(20, 1);
      pct = $urandom_range(100, 25);
      ew  = (n + PN - 1) / PN;
      lm  = (n % PN == 0) ? 4'hF : PN'((1 << (n % PN)) - 1);
      run_frame(b, n, pct, $urandom_range(60, 0), r[0], 1'b1, ew, b + AW'(ew - 1), lm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
